// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - registered N-channel W-bit mux with direct select and masked scan sweep
// Output register loads whenever the held beat is absent or being accepted.
module scan_mux #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 16,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic [CHANNELS-1:0]       en_mask,
   input  logic                      start,
   input  logic [CHANNELS*WIDTH-1:0] d,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          q,
   output logic [SEL_W-1:0]          q_ch,
   output logic                      out_valid,
   output logic                      busy,
   output logic                      done
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [SEL_W-1:0] LAST = SEL_W'(CHANNELS - 1);

   state_t                state, state_nxt;
   logic [SEL_W-1:0]      ptr;
   logic [CHANNELS-1:0]   mask_l;
   logic                  load;
   logic                  ld_beat;
   logic                  clr_valid;
   logic                  ptr_adv;
   logic                  latch;
   logic [SEL_W-1:0]      beat_idx;

   // Indices with no matching channel (sel >= CHANNELS) read as zero.
   function automatic logic [WIDTH-1:0] chan_data(input logic [SEL_W-1:0] idx,
                                                  input logic [CHANNELS*WIDTH-1:0] bus);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (idx == SEL_W'(i)) r = bus[i*WIDTH +: WIDTH];
      end
      return r;
   endfunction

   assign load = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ld_beat   = 1'b0;
      clr_valid = 1'b0;
      ptr_adv   = 1'b0;
      latch     = 1'b0;
      beat_idx  = sel;
      case (state)
         IDLE: begin
            if (!mode) begin
               ld_beat = load;
            end else begin
               clr_valid = load;
               if (start) begin
                  latch     = 1'b1;
                  state_nxt = SCAN;
               end
            end
         end
         SCAN: begin
            beat_idx = ptr;
            if (mask_l[ptr]) begin
               ld_beat = load;
               ptr_adv = load;
            end else begin
               clr_valid = load;
               ptr_adv   = 1'b1;
            end
            if (ptr_adv && ptr == LAST) state_nxt = DONE;
         end
         DONE: begin
            clr_valid = load;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q         <= '0;
         q_ch      <= '0;
         out_valid <= 1'b0;
         ptr       <= '0;
         mask_l    <= '0;
      end else begin
         if (ld_beat) begin
            q         <= chan_data(beat_idx, d);
            q_ch      <= beat_idx;
            out_valid <= 1'b1;
         end else if (clr_valid) begin
            out_valid <= 1'b0;
         end
         if (latch) begin
            mask_l <= en_mask;
            ptr    <= '0;
         end else if (ptr_adv) begin
            ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
         end
      end
   end

endmodule
